// File: rtl/fetch_icache_dm.sv
// Purpose : direct-mapped instruction cache between the fetch PC and instruction memory.
// Latency : hit -> instr_valid the cycle after acceptance; miss -> acceptance + 1 + mem wait cycles + 1.
// Backpressure: busy=1 during refill/response (and while a deferred flush is applied); cpu_req is dropped, not queued.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpu_req/cpu_addr  fetch request (word address), accepted when busy==0 and flush==0
//   flush             invalidate every line (deferred to the first idle cycle if a refill is in flight)
//   busy              cache not accepting requests
//   instr_valid       one-cycle pulse, instruction carries the fetched word
//   mem_req/mem_addr  line refill request (line-aligned), held until mem_ack
//   mem_ack/mem_data  one-cycle refill response carrying the whole line (word i at [i*DATA_W +: DATA_W])
//   hit_count/miss_count  saturating accepted-hit / accepted-miss counters, present only
//                         when ICACHE_STATS_EN is defined
module fetch_icache_dm #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_SETS       = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cpu_req,
    input  logic [ADDR_W-1:0]                cpu_addr,
    input  logic                             flush,
    output logic                             busy,
    output logic                             instr_valid,
    output logic [DATA_W-1:0]                instruction,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_ack,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                      hit_count,
    output logic [31:0]                      miss_count
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = DATA_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    // Line storage. Only the valid bits are reset; tag/data contents are
    // meaningless until their valid bit is set by a refill.
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [LINE_W-1:0]   data_mem [NUM_SETS];

    // Request decode
    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  lookup_tag;
    logic [LINE_W-1:0] lookup_line;
    logic              hit;
    logic              accept;
    logic [DATA_W-1:0] hit_word;

    // State of the outstanding miss
    logic [OFF_W-1:0]  lat_off;
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic [DATA_W-1:0] ack_word;
    logic [DATA_W-1:0] resp_word_q;
    logic              flush_pend_q;

    assign req_off     = cpu_addr[OFF_W-1:0];
    assign req_idx     = cpu_addr[OFF_W +: IDX_W];
    assign req_tag     = cpu_addr[ADDR_W-1 -: TAG_W];
    assign lookup_tag  = tag_mem[req_idx];
    assign lookup_line = data_mem[req_idx];
    assign hit         = valid_q[req_idx] && (lookup_tag == req_tag);

    // A deferred flush occupies the first idle cycle, so the cache reports
    // busy then as well as during refill/response.
    assign busy   = (state_q != ST_IDLE) || flush_pend_q;
    assign accept = cpu_req && !busy && !flush;

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (req_off == OFF_W'(w)) begin
                hit_word = lookup_line[w*DATA_W +: DATA_W];
            end
        end
    end

    // Only the requested word of the refill line has to survive until the
    // response cycle; the full line goes straight into data_mem.
    always_comb begin
        ack_word = '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (lat_off == OFF_W'(w)) begin
                ack_word = mem_data[w*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept && !hit) state_d = ST_REFILL;
            ST_REFILL: if (mem_ack)        state_d = ST_RESP;
            ST_RESP:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            instr_valid  <= 1'b0;
            instruction  <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            lat_off      <= '0;
            lat_idx      <= '0;
            lat_tag      <= '0;
            resp_word_q  <= '0;
        end else begin
            instr_valid <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (flush_pend_q || flush) begin
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end
                    if (accept) begin
                        if (hit) begin
                            instr_valid <= 1'b1;
                            instruction <= hit_word;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            lat_off  <= req_off;
                            lat_idx  <= req_idx;
                            lat_tag  <= req_tag;
                        end
                    end
                end
                ST_REFILL: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (mem_ack) begin
                        valid_q[lat_idx] <= 1'b1;
                        resp_word_q      <= ack_word;
                        mem_req          <= 1'b0;
                    end
                end
                ST_RESP: begin
                    // The in-flight word is delivered even if a flush has
                    // already been recorded against the new line.
                    if (flush) flush_pend_q <= 1'b1;
                    instr_valid <= 1'b1;
                    instruction <= resp_word_q;
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays: written only on a refill response, never reset.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_REFILL) && mem_ack) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= mem_data;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_icache_dm.sv
// Purpose : self-checking bench for fetch_icache_dm (default geometry: 4 words/line, 64 sets).
// Latency : expectations are formed one cycle ahead from a transaction-level cache model.
// Backpressure: the bench plays instruction memory, acking refills after random delays.
module tb_fetch_icache_dm;

    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic [31:0]   cpu_addr;
    logic          flush;
    logic          busy;
    logic          instr_valid;
    logic [31:0]   instruction;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [LW-1:0] mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    fetch_icache_dm dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .flush       (flush),
        .busy        (busy),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Backing instruction memory: line 0x104 holds 0x11,0x22,0x33,0x44,
    // everything else is a hash of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] base;
        base = a & ~32'h3;
        if (base == 32'h104) return 32'h11 * ({30'd0, a[1:0]} + 32'd1);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // ---------------- transaction-level cache model ----------------
    // Which line address each set holds, whether a miss is waiting for
    // memory, whether a response is due, and whether a flush is deferred.
    bit          mvalid [64];
    logic [31:0] mline  [64];
    bit          outst, deliv, fdef;
    logic [31:0] miss_addr, miss_line, resp_word;
    bit          m_iv;
    logic [31:0] m_ins;
    int unsigned m_hits, m_misses;

    // Expected outputs for the current cycle
    bit          chk_en = 0;
    bit          exp_busy, exp_mem_req, exp_iv;
    logic [31:0] exp_mem_addr, exp_ins;
    int unsigned exp_hits, exp_misses;

    task automatic model_edge(input bit r, input bit rq, input logic [31:0] a,
                              input bit fl, input bit ak);
        int idx;
        if (r) begin
            foreach (mvalid[i]) mvalid[i] = 0;
            outst = 0; deliv = 0; fdef = 0;
            m_iv = 0; m_ins = 0; miss_line = 0; miss_addr = 0;
            m_hits = 0; m_misses = 0;
            return;
        end
        m_iv = 0;
        if (outst) begin
            if (fl) fdef = 1;
            if (ak) begin
                idx = int'((miss_line >> 2) & 32'h3F);
                mvalid[idx] = 1;
                mline[idx]  = miss_line;
                resp_word   = memword(miss_addr);
                outst = 0;
                deliv = 1;
            end
        end else if (deliv) begin
            if (fl) fdef = 1;
            m_iv  = 1;
            m_ins = resp_word;
            deliv = 0;
        end else if (fdef || fl) begin
            foreach (mvalid[i]) mvalid[i] = 0;
            fdef = 0;
        end else if (rq) begin
            idx = int'((a >> 2) & 32'h3F);
            if (mvalid[idx] && mline[idx] == (a & ~32'h3)) begin
                m_iv  = 1;
                m_ins = memword(a);
                m_hits++;
            end else begin
                outst     = 1;
                miss_addr = a;
                miss_line = a & ~32'h3;
                m_misses++;
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model across the edge,
    // then publish the post-edge expectations.
    task automatic step(input bit r, input bit rq, input logic [31:0] a,
                        input bit fl, input bit ak);
        rst = r; cpu_req = rq; cpu_addr = a; flush = fl; mem_ack = ak;
        for (int i = 0; i < 4; i++) begin
            mem_data[i*32 +: 32] = (outst && ak) ? memword(miss_line + 32'(i)) : $urandom();
        end
        model_edge(r, rq, a, fl, ak);
        @(posedge clk);
        #1;
        exp_busy     = outst || deliv || fdef;
        exp_mem_req  = outst;
        exp_mem_addr = miss_line;
        exp_iv       = m_iv;
        exp_ins      = m_ins;
        exp_hits     = m_hits;
        exp_misses   = m_misses;
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 0);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",        32'(busy),        32'(exp_busy));
            check("mem_req",     32'(mem_req),     32'(exp_mem_req));
            check("mem_addr",    mem_addr,         exp_mem_addr);
            check("instr_valid", 32'(instr_valid), 32'(exp_iv));
            check("instruction", instruction,      exp_ins);
`ifdef ICACHE_STATS_EN
            check("hit_count",   hit_count,        exp_hits);
            check("miss_count",  miss_count,       exp_misses);
`endif
        end
    end

    initial begin
        rst = 1; cpu_req = 0; cpu_addr = 0; flush = 0; mem_ack = 0; mem_data = '0;

        // Reset
        step(1, 0, 32'h0, 0, 0);
        chk_en = 1;
        step(1, 0, 32'h0, 0, 0);
        idle();
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_req",   32'(mem_req),     32'd0);
        check("rst_iv",    32'(instr_valid), 32'd0);
        check("rst_ins",   instruction,      32'd0);
        check("rst_maddr", mem_addr,         32'd0);

        // Cold miss on 0x105, ack after 3 wait cycles
        step(0, 1, 32'h105, 0, 0);
        check("miss_busy",  32'(busy),    32'd1);
        check("miss_req",   32'(mem_req), 32'd1);
        check("miss_maddr", mem_addr,     32'h104);
        repeat (3) idle();
        step(0, 0, 32'h0, 0, 1);
        check("resp_iv_early", 32'(instr_valid), 32'd0);
        idle();
        check("fill_iv",  32'(instr_valid), 32'd1);
        check("fill_ins", instruction,      32'h22);

        // Back-to-back hits across the filled line
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h104 + 32'(i), 0, 0);
            check("b2b_iv",  32'(instr_valid), 32'd1);
            check("b2b_ins", instruction,      32'h11 * 32'(i + 1));
            check("b2b_req", 32'(mem_req),     32'd0);
        end
`ifdef ICACHE_STATS_EN
        check("stat_miss", miss_count, 32'd1);
        check("stat_hit",  hit_count,  32'd4);
`endif
        idle();

        // Alias on set 1 evicts 0x104's line
        step(0, 1, 32'h504, 0, 0);
        check("alias_req",   32'(mem_req), 32'd1);
        check("alias_maddr", mem_addr,     32'h504);
        step(0, 0, 32'h0, 0, 1);
        idle();
        step(0, 1, 32'h104, 0, 0);
        check("realias_req",   32'(mem_req), 32'd1);
        check("realias_maddr", mem_addr,     32'h104);
        step(0, 0, 32'h0, 0, 1);
        idle();
        check("realias_ins", instruction, 32'h11);

        // Flush during refill wait: word still delivered, line then invalid
        step(0, 1, 32'h200, 0, 0);
        idle();
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 1);
        idle();
        check("fl_iv",   32'(instr_valid), 32'd1);
        check("fl_busy", 32'(busy),        32'd1);
        idle();
        check("fl_busy_clr", 32'(busy), 32'd0);
        step(0, 1, 32'h200, 0, 0);
        check("fl_remiss", 32'(mem_req), 32'd1);
        step(0, 0, 32'h0, 0, 1);
        idle();

        // Request coinciding with flush in idle is dropped
        step(0, 1, 32'h300, 0, 0);
        step(0, 0, 32'h0, 0, 1);
        idle();
        step(0, 1, 32'h300, 1, 0);
        check("flreq_iv",  32'(instr_valid), 32'd0);
        check("flreq_req", 32'(mem_req),     32'd0);
        step(0, 1, 32'h300, 0, 0);
        check("flreq_remiss", 32'(mem_req), 32'd1);
        step(0, 0, 32'h0, 0, 1);
        idle();

        // Reset in the middle of a refill, then a stale ack
        step(0, 1, 32'h400, 0, 0);
        idle();
        step(1, 0, 32'h0, 0, 0);
        check("rstmid_req",  32'(mem_req), 32'd0);
        check("rstmid_busy", 32'(busy),    32'd0);
        step(0, 0, 32'h0, 0, 1);
        idle();
        check("late_ack_iv", 32'(instr_valid), 32'd0);

        // Randomized traffic over a small address pool to force hits and aliasing
        for (int n = 0; n < 4000; n++) begin
            bit          r, rq, fl, ak;
            logic [31:0] a;
            r  = ($urandom_range(0, 299) == 0);
            fl = ($urandom_range(0, 19) == 0);
            rq = ($urandom_range(0, 1) == 1);
            a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            ak = outst ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step(r, rq, a, fl, ak);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
